fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Controller that owns and sequences the 8-bit program counter feeding the 9-bit instruction ROM.
- Starts and stops program execution.
- Applies taken branches, stalls, and a small call/return stack.
- Reports completion, fault status and a cycle count for benchmarking.
- Sits between the decoder/ALU flag logic and the instruction memory. It replaces the free-running PC increment with an explicit run-control FSM.

Parameters:
NUM_INSTR, 256, number of valid instruction words; legal PC range 0..NUM_INSTR-1 (2..256)
STACK_DEPTH, 4, return-address stack entries (1..8)

Ports:
CLK  input  1  clock, all state updates on rising edge
init_n  input  1  asynchronous active-low reset
start  input  1  begin execution from address 0 (honoured in IDLE and DONE)
halt  input  1  decoded halt instruction at current PC
stall  input  1  current instruction needs another cycle; hold PC
branch  input  1  decoded branch instruction
jump  input  1  branch condition flag from ALU
call  input  1  decoded call instruction
ret  input  1  decoded return instruction
address  input  8  branch/call target
pc  output  8  instruction ROM address (registered)
running  output  1  high in RUN
done  output  1  high in DONE
fault  output  1  sticky error flag, valid in DONE
cycle_count  output  16  cycles spent in RUN, saturating

Behaviour:
- Reset (init_n=0, asynchronous):
  - State IDLE; pc=0, sp=0, done=0, running=0, fault=0, cycle_count=0.
  - Stack contents are don't-care.
- All outputs are registered. Decode inputs are sampled only in RUN.
- States and transitions:
  - IDLE: pc held at 0. start=1 -> RUN next edge, with pc=0, cycle_count=0, sp=0, fault=0.
  - RUN: one action per cycle, in this fixed priority order:
    1. halt: -> DONE; pc unchanged.
    2. stall: pc, sp and state unchanged.
    3. branch & jump: pc <= address.
    4. call: if sp<STACK_DEPTH, push pc+1 (8-bit wrap) and pc <= address. Otherwise overflow: fault=1, -> DONE, pc unchanged.
    5. ret: if sp>0, pop into pc. Otherwise underflow: fault=1, -> DONE, pc unchanged.
    6. Otherwise sequential: if pc==NUM_INSTR-1, run-off: fault=1, -> DONE, pc unchanged. Else pc <= pc+1.
  - branch with jump=0 falls through to the lower-priority rules; it is normally sequential.
  - DONE: pc, fault and cycle_count frozen; done=1. start=1 -> RUN with the same clear as from IDLE.
- cycle_count:
  - Increments on every RUN cycle, including stall cycles and the cycle that exits to DONE.
  - Saturates at 0xFFFF and never wraps.
- A target address >= NUM_INSTR is accepted unchanged. The ROM returns don't-care; no fault is raised.
- Simultaneous call and ret: call wins per the priority order.
- start while in RUN is ignored.
- Reset mid-operation aborts immediately to IDLE, regardless of state.
- Latency:
  - Control inputs in cycle N affect pc at edge N+1.
  - done rises at the edge after halt is sampled.

Test Plan:
- Reset then start pulse, no decode inputs, NUM_INSTR=8: pc steps 0..7. On the edge after pc=7: done=1, fault=1 (run-off), cycle_count=8.
- At pc=3: branch=1, jump=1, address=0x20 -> pc=0x20 next cycle. Same with jump=0 -> pc=4. Halt at pc=0x22 -> done=1, fault=0, pc stays 0x22.
- At pc=5: call with address=0x40 -> pc=0x40, sp=1. Two sequential cycles, then ret at 0x42 -> pc=6, sp=0. Fifth nested call with STACK_DEPTH=4 -> fault=1, done=1. Ret with sp=0 -> fault=1.
- stall held 3 cycles at pc=9, with branch+jump also asserted -> pc stays 9 and cycle_count advances by 3. stall drops with branch still high -> pc <= address.
- Assert init_n=0 asynchronously mid-RUN at pc=0x15 -> outputs clear before the next edge. start after release -> pc=0, cycle_count restarts from 0.
- Force 70000 RUN cycles using a loop branch -> cycle_count=0xFFFF, held. Halt, then start again from DONE -> pc=0, fault=0, cycle_count=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
`timescale 1ns/1ps
// fetch_sequencer: run-control FSM owning the 8-bit program counter that
// addresses the instruction ROM. It handles start/halt, stalls, taken
// branches, a small return-address stack, and fault detection for
// run-off, stack overflow and stack underflow. It also keeps a saturating
// count of RUN cycles.
module fetch_sequencer #(
  parameter int NUM_INSTR   = 256,
  parameter int STACK_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        init_n,
  input  logic        start,
  input  logic        halt,
  input  logic        stall,
  input  logic        branch,
  input  logic        jump,
  input  logic        call,
  input  logic        ret,
  input  logic [7:0]  address,
  output logic [7:0]  pc,
  output logic        running,
  output logic        done,
  output logic        fault,
  output logic [15:0] cycle_count
);

  // sp counts 0..STACK_DEPTH, so it needs one value more than the entry count
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam int STACK_SLOTS = 2 ** SP_W;
  localparam logic [7:0] LAST_PC = 8'(NUM_INSTR - 1);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [7:0]      pc_nxt;
  logic [SP_W-1:0] sp;
  logic [SP_W-1:0] sp_nxt;
  logic [SP_W-1:0] top_idx;
  logic            fault_nxt;
  logic [15:0]     count_nxt;
  logic [15:0]     count_inc;
  logic [7:0]      pc_plus1;
  logic            push_en;
  // Storage is sized to the full index range of sp so that indexing is
  // always in bounds; only the first STACK_DEPTH slots are ever written.
  logic [7:0]      stack [STACK_SLOTS];

  assign pc_plus1  = pc + 8'd1;
  assign top_idx   = sp - SP_W'(1);
  assign count_inc = (cycle_count == 16'hFFFF) ? cycle_count : (cycle_count + 16'd1);

  // Next-state and next-value logic. In RUN exactly one action is taken per cycle, in priority order.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    sp_nxt    = sp;
    fault_nxt = fault;
    count_nxt = cycle_count;
    push_en   = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_RUN;
          pc_nxt    = 8'd0;
          sp_nxt    = {SP_W{1'b0}};
          fault_nxt = 1'b0;
          count_nxt = 16'd0;
        end else begin
          state_nxt = state;
        end
      end
      S_RUN: begin
        count_nxt = count_inc;
        if (halt) begin
          state_nxt = S_DONE;
        end else if (stall) begin
          state_nxt = S_RUN;
        end else if (branch && jump) begin
          pc_nxt = address;
        end else if (call) begin
          if (sp < SP_FULL) begin
            push_en = 1'b1;
            sp_nxt  = sp + SP_W'(1);
            pc_nxt  = address;
          end else begin
            fault_nxt = 1'b1;
            state_nxt = S_DONE;
          end
        end else if (ret) begin
          if (sp != {SP_W{1'b0}}) begin
            sp_nxt = top_idx;
            pc_nxt = stack[top_idx];
          end else begin
            fault_nxt = 1'b1;
            state_nxt = S_DONE;
          end
        end else if (pc == LAST_PC) begin
          // falling off the end of the program is a fault, not a wrap
          fault_nxt = 1'b1;
          state_nxt = S_DONE;
        end else begin
          pc_nxt = pc_plus1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        pc_nxt    = 8'd0;
        sp_nxt    = {SP_W{1'b0}};
        fault_nxt = 1'b0;
        count_nxt = 16'd0;
      end
    endcase
  end

  // Control registers; running/done are decoded from the next state so they are registered outputs.
  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      state       <= S_IDLE;
      pc          <= 8'd0;
      sp          <= {SP_W{1'b0}};
      fault       <= 1'b0;
      cycle_count <= 16'd0;
      running     <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      sp          <= sp_nxt;
      fault       <= fault_nxt;
      cycle_count <= count_nxt;
      running     <= (state_nxt == S_RUN);
      done        <= (state_nxt == S_DONE);
    end
  end

  // Return-address stack. A push stores the address after the call site, wrapping in 8 bits.
  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      for (int i = 0; i < STACK_SLOTS; i++) begin
        stack[i] <= 8'd0;
      end
    end else if (push_en) begin
      stack[sp] <= pc_plus1;
    end else begin
      stack[sp] <= stack[sp];
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
`timescale 1ns/1ps
// Directed bench for fetch_sequencer. A behavioural model predicts every
// cycle of the 256-word instance, and a queue carries those predictions to
// the compare point. A second, 8-word instance covers program run-off.
module tb_fetch_sequencer;

  logic        CLK;
  logic        init_n;
  logic        start, halt, stall, branch, jump, call, ret;
  logic [7:0]  address;

  logic [7:0]  pc, sm_pc;
  logic        running, sm_running;
  logic        done, sm_done;
  logic        fault, sm_fault;
  logic [15:0] cycle_count, sm_cycle_count;

  fetch_sequencer #(.NUM_INSTR(256), .STACK_DEPTH(4)) u_dut (
    .CLK(CLK), .init_n(init_n), .start(start), .halt(halt), .stall(stall),
    .branch(branch), .jump(jump), .call(call), .ret(ret), .address(address),
    .pc(pc), .running(running), .done(done), .fault(fault),
    .cycle_count(cycle_count)
  );

  fetch_sequencer #(.NUM_INSTR(8), .STACK_DEPTH(4)) u_small (
    .CLK(CLK), .init_n(init_n), .start(start), .halt(halt), .stall(stall),
    .branch(branch), .jump(jump), .call(call), .ret(ret), .address(address),
    .pc(sm_pc), .running(sm_running), .done(sm_done), .fault(sm_fault),
    .cycle_count(sm_cycle_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0]  pc;
    logic        running;
    logic        done;
    logic        fault;
    logic [15:0] cc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state: 0 idle, 1 run, 2 done
  int          m_state;
  logic [7:0]  m_pc;
  int          m_sp;
  logic        m_fault;
  logic [15:0] m_cc;
  logic [7:0]  m_stack [4];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pc = 8'd0; m_sp = 0; m_fault = 1'b0; m_cc = 16'd0;
  endtask

  task automatic model_step();
    if (m_state == 1) begin
      if (m_cc != 16'hFFFF) m_cc = m_cc + 16'd1;
      if (halt) m_state = 2;
      else if (stall) begin end
      else if (branch && jump) m_pc = address;
      else if (call) begin
        if (m_sp < 4) begin
          m_stack[m_sp] = m_pc + 8'd1;
          m_sp++;
          m_pc = address;
        end else begin
          m_fault = 1'b1; m_state = 2;
        end
      end else if (ret) begin
        if (m_sp > 0) begin
          m_sp--;
          m_pc = m_stack[m_sp];
        end else begin
          m_fault = 1'b1; m_state = 2;
        end
      end else if (m_pc == 8'hFF) begin
        m_fault = 1'b1; m_state = 2;
      end else begin
        m_pc = m_pc + 8'd1;
      end
    end else if (start) begin
      m_state = 1; m_pc = 8'd0; m_sp = 0; m_fault = 1'b0; m_cc = 16'd0;
    end
  endtask

  // Drive one cycle of inputs (called 1 time unit after a rising edge),
  // queue the prediction, then compare one time unit after the next edge.
  task automatic step(input logic s, input logic h, input logic st, input logic b,
                      input logic j, input logic c, input logic r, input logic [7:0] a);
    exp_t e;
    start = s; halt = h; stall = st; branch = b; jump = j; call = c; ret = r; address = a;
    model_step();
    e.pc = m_pc; e.running = (m_state == 1); e.done = (m_state == 2);
    e.fault = m_fault; e.cc = m_cc;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk("pc", {8'd0, pc}, {8'd0, e.pc});
    chk("running", {15'd0, running}, {15'd0, e.running});
    chk("done", {15'd0, done}, {15'd0, e.done});
    chk("fault", {15'd0, fault}, {15'd0, e.fault});
    chk("cycle_count", cycle_count, e.cc);
  endtask

  task automatic seq(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  initial begin
    init_n = 1'b0;
    start = 1'b0; halt = 1'b0; stall = 1'b0; branch = 1'b0; jump = 1'b0;
    call = 1'b0; ret = 1'b0; address = 8'd0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_pc", {8'd0, pc}, 16'd0);
    chk("rst_running", {15'd0, running}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_fault", {15'd0, fault}, 16'd0);
    chk("rst_cc", cycle_count, 16'd0);
    #2 init_n = 1'b1;
    @(posedge CLK); #1;

    // start, then free-run; the 8-word instance runs off the end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("sm_pc_start", {8'd0, sm_pc}, 16'd0);
    chk("sm_running", {15'd0, sm_running}, 16'd1);
    for (int i = 1; i < 8; i++) begin
      seq(1);
      chk("sm_pc_step", {8'd0, sm_pc}, 16'(i));
    end
    seq(1);
    chk("sm_runoff_done", {15'd0, sm_done}, 16'd1);
    chk("sm_runoff_fault", {15'd0, sm_fault}, 16'd1);
    chk("sm_runoff_cc", sm_cycle_count, 16'd8);
    chk("sm_runoff_pc", {8'd0, sm_pc}, 16'd7);
    chk("big_pc_8", {8'd0, pc}, 16'd8);

    // start is ignored while running; halt parks in DONE
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // branches and halt
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    seq(3);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h20);
    chk("branch_taken", {8'd0, pc}, 16'h0020);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
    chk("branch_not_taken", {8'd0, pc}, 16'h0021);
    seq(1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("halt_pc", {8'd0, pc}, 16'h0022);
    chk("halt_done", {15'd0, done}, 16'd1);
    chk("halt_fault", {15'd0, fault}, 16'd0);
    seq(2);

    // call / return, call-over-ret priority, overflow
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    seq(5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h40);
    seq(2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    chk("ret_pc", {8'd0, pc}, 16'h0006);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h50);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h60);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h70);
    chk("call_beats_ret", {8'd0, pc}, 16'h0070);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h90);
    chk("overflow_fault", {15'd0, fault}, 16'd1);
    chk("overflow_done", {15'd0, done}, 16'd1);
    chk("overflow_pc", {8'd0, pc}, 16'h0080);

    // underflow
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    chk("underflow_fault", {15'd0, fault}, 16'd1);
    chk("underflow_pc", {8'd0, pc}, 16'd0);

    // call at the top address pushes a wrapped return address; then run-off at 0xFF
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h30);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    chk("ret_wrap_pc", {8'd0, pc}, 16'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
    seq(1);
    chk("runoff_ff_fault", {15'd0, fault}, 16'd1);

    // stall outranks a taken branch and still counts cycles
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    seq(9);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h30);
    chk("stall_pc", {8'd0, pc}, 16'h0009);
    chk("stall_cc", cycle_count, 16'd12);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h30);
    chk("post_stall_branch", {8'd0, pc}, 16'h0030);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h15);

    // asynchronous reset mid-RUN
    #2 init_n = 1'b0;
    #1;
    model_reset();
    chk("arst_pc", {8'd0, pc}, 16'd0);
    chk("arst_running", {15'd0, running}, 16'd0);
    chk("arst_cc", cycle_count, 16'd0);
    #2 init_n = 1'b1;
    @(posedge CLK); #1;
    seq(1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    seq(2);
    chk("restart_cc", cycle_count, 16'd2);

    // saturation of the cycle counter on a tight loop
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 70000; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h10);
    chk("sat_cc", cycle_count, 16'hFFFF);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("sat_halt_cc", cycle_count, 16'hFFFF);
    chk("sat_halt_done", {15'd0, done}, 16'd1);
    seq(1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("restart_done_pc", {8'd0, pc}, 16'd0);
    chk("restart_done_fault", {15'd0, fault}, 16'd0);
    chk("restart_done_cc", cycle_count, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
